// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants, output-stage state encoding and the
//                one-hot to binary helper for the 4-to-1 arbitrated mux.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Binary index of the set bit; zero when no bit is set.
    function automatic logic [SEL_W-1:0] onehot_to_bin(input logic [NUM_CH-1:0] oh);
        logic [SEL_W-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) begin
                b = b | SEL_W'(i);
            end
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arbiter
//  Description : Four-way arbiter. Round-robin by default, with the search
//                starting at the internal rotation pointer, which moves to
//                one past the granted channel whenever adv is high.
//                Build macro MUX_FIXED_PRIO_EN selects fixed priority
//                (channel 0 highest); the rotation pointer then disappears
//                and ptr reads as zero.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_rr_arbiter
    import mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              adv,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic [SEL_W-1:0]  ptr
);

`ifdef MUX_FIXED_PRIO_EN
    // Clock, reset and advance have no state to drive in this mode.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, adv};
    assign ptr       = '0;

    // Lowest-numbered requester wins.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`else
    logic [SEL_W-1:0] rr_ptr;

    // Rotation pointer: moves past the channel just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (adv) begin
            rr_ptr <= gnt_idx + SEL_W'(1);
        end
    end

    // First requester found scanning upward from rr_ptr, wrapping modulo 4.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = rr_ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign ptr = rr_ptr;
`endif

    assign gnt_idx = onehot_to_bin(gnt);

endmodule
`default_nettype wire

// File: rtl/multiplexer_4_to_1_arb_module.sv
`default_nettype none
// ============================================================================
//  Module      : multiplexer_4_to_1_arb_module
//  Description : Merges four valid/ready channels into one registered output
//                stream tagged with the source channel on out_sel. One output
//                register stage; arbitration in mux_rr_arbiter. Build macro
//                MUX_FIXED_PRIO_EN switches the arbiter to fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
module multiplexer_4_to_1_arb_module
    import mux_pkg::*;
#(
    parameter int DW = 8
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH*DW-1:0] in_data,
    output logic [NUM_CH-1:0]    in_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    out_state_t        state;
    out_state_t        state_nxt;
    logic              can_accept;
    logic              load;
    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic [SEL_W-1:0]  arb_ptr;
    logic [DW-1:0]     gnt_data;

    // The register can take a word when empty or being drained this cycle.
    assign can_accept = (state == EMPTY) || out_ready;
    assign load       = can_accept && (|in_valid);
    assign in_ready   = gnt & {NUM_CH{can_accept}} & {NUM_CH{~rst}};
    assign out_valid  = (state == FULL);

    mux_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .adv     (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .ptr     (arb_ptr)
    );

    // Pointer is observable for debug only.
    logic unused_ptr;
    assign unused_ptr = &{1'b0, arb_ptr};

    // Select the granted channel's word.
    always_comb begin
        gnt_data = in_data[gnt_idx*DW +: DW];
    end

    // Output-stage state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: fill on load, empty when drained with nothing to refill.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (load) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Output data and tag; held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (load) begin
            out_data <= gnt_data;
            out_sel  <= gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplexer_4_to_1_arb_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplexer_4_to_1_arb_module
//  Description : Self-checking bench. A reference model tracks fullness and
//                the rotation pointer, pushes expected {tag,data} on every
//                accepted input and pops on every output transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multiplexer_4_to_1_arb_module;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [3:0]    in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    multiplexer_4_to_1_arb_module #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference grant: first valid channel scanning upward from ptr.
    function automatic logic [1:0] ref_grant(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] g;
        logic [1:0] k;
        logic       f;
        g = 2'd0;
        f = 1'b0;
        for (int i = 0; i < 4; i++) begin
            k = p + 2'(i);
            if (!f && v[k]) begin
                g = k;
                f = 1'b1;
            end
        end
        return g;
    endfunction

    // Scoreboard and model state
    logic [9:0] sb_q[$];
    logic [1:0] sel_log[$];
    logic       m_full = 1'b0;
    logic [1:0] m_ptr  = 2'd0;

    // Model runs on the falling edge, using inputs that the next rising
    // edge will sample.
    always @(negedge clk) begin
        logic       can;
        logic [1:0] g;
        logic [3:0] exp_rdy;
        logic       ld;
        if (rst) begin
            check("in_ready_rst", {28'd0, in_ready}, 32'd0);
            sb_q.delete();
            m_full = 1'b0;
            m_ptr  = 2'd0;
        end else begin
            can     = !m_full || out_ready;
            ld      = can && (|in_valid);
`ifdef MUX_FIXED_PRIO_EN
            g       = ref_grant(in_valid, 2'd0);
`else
            g       = ref_grant(in_valid, m_ptr);
`endif
            exp_rdy = ld ? (4'b0001 << g) : 4'b0000;
            check("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
            if (m_full && sb_q.size() > 0) begin
                check("out_sel", {30'd0, out_sel}, {30'd0, sb_q[0][9:8]});
                check("out_data", {24'd0, out_data}, {24'd0, sb_q[0][7:0]});
            end
            if (out_valid && out_ready) begin
                sel_log.push_back(out_sel);
            end
            if (m_full && out_ready && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
            end
            if (ld) begin
                sb_q.push_back({g, in_data[g*DW +: DW]});
`ifndef MUX_FIXED_PRIO_EN
                m_ptr = g + 2'd1;
`endif
            end
            m_full = ld ? 1'b1 : ((m_full && out_ready) ? 1'b0 : m_full);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                             input logic [1:0] e2, input logic [1:0] e3);
        logic [1:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            if (sel_log.size() > 0) begin
                check(tag, {30'd0, sel_log.pop_front()}, {30'd0, e[i]});
            end else begin
                check(tag, 32'hDEAD, {30'd0, e[i]});
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;

        // Reset with all channels valid
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sel", {30'd0, out_sel}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_in_ready", {28'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("first_grant", {28'd0, in_ready}, 32'h1);
        step();
        in_valid = 4'h0;
        step();
        step();
        sel_log.delete();

        // Single channel 2 (pointer now 1; lands on 3 afterwards)
        in_valid = 4'b0100;
        in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        #1;
        check("single_ready", {28'd0, in_ready}, 32'h4);
        step();
        in_valid = 4'h0;
        #1;
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_data", {24'd0, out_data}, 32'hA5);
        check("single_sel", {30'd0, out_sel}, 32'd2);
        step();
        sel_log.delete();

        // Wrap: channels 3 and 0 only, pointer at 3
        in_valid = 4'b1001;
        in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        repeat (4) step();
        in_valid = 4'h0;
        step();
        step();
`ifdef MUX_FIXED_PRIO_EN
        check_log("wrap_seq", 2'd0, 2'd0, 2'd0, 2'd0);
`else
        check_log("wrap_seq", 2'd3, 2'd0, 2'd3, 2'd0);
`endif

        // Reset pointer, then all channels valid for 8 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        sel_log.delete();
        in_valid = 4'hF;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (8) step();
        in_valid = 4'h0;
        step();
        check("burst_count", sel_log.size(), 32'd8);
`ifdef MUX_FIXED_PRIO_EN
        check_log("burst_seq", 2'd0, 2'd0, 2'd0, 2'd0);
        check_log("burst_seq", 2'd0, 2'd0, 2'd0, 2'd0);
`else
        check_log("burst_seq", 2'd0, 2'd1, 2'd2, 2'd3);
        check_log("burst_seq", 2'd0, 2'd1, 2'd2, 2'd3);
`endif
        step();
        sel_log.delete();

        // Backpressure: load channel 0, then stall 5 cycles with changing inputs
        in_valid = 4'hF;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom();
            step();
            check("bp_sel_hold", {30'd0, out_sel}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
`ifdef MUX_FIXED_PRIO_EN
        check("bp_release", {28'd0, in_ready}, 32'h1);
`else
        check("bp_release", {28'd0, in_ready}, 32'h2);
`endif
        step();
        in_valid = 4'h0;
        step();
        step();

        // Reset while full and stalled
        in_valid  = 4'hF;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_full_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_full_grant", {28'd0, in_ready}, 32'h1);
        out_ready = 1'b1;
        step();
        in_valid = 4'h0;
        step();
        step();
        check("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
